// File: rtl/sfilt_pkg.sv
// Shared definitions for the sfilt command sequencer: sfilt command codes and FSM states.
package sfilt_pkg;

    localparam logic [1:0] CMD_MULT = 2'd0;
    localparam logic [1:0] CMD_MAC  = 2'd1;
    localparam logic [1:0] CMD_SHR  = 2'd2;
    localparam logic [1:0] CMD_SEND = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        MULT0,
        MAC,
        SHIFT,
        SEND
    } sfilt_state_e;

endpackage

// File: rtl/sfilt_seq_if.sv
// Sample handshake plus the sfilt command bus driven by the sequencer.
interface sfilt_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [6:0]  shift;
    logic        pushout;
    logic [1:0]  cmd;
    logic [31:0] q;
    logic [31:0] h;

    // master: sample source / command consumer; slave: the sequencer
    modport master (
        output in_valid, in_data, shift,
        input  in_ready, pushout, cmd, q, h
    );

    modport slave (
        input  in_valid, in_data, shift,
        output in_ready, pushout, cmd, q, h
    );

endinterface

// File: rtl/sfilt_seq_hist.sv
// NTAPS x 32 circular sample history; write at wptr+1, read at wptr-rd_off (modulo NTAPS).
module sfilt_seq_hist #(
    parameter int unsigned NTAPS = 8,
    parameter int unsigned AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          clr,
    input  logic [AW-1:0] rd_off,
    output logic [31:0]   rd_data
);

    logic [31:0]   mem_q [NTAPS];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] base;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    // A clear coinciding with a push rebases the write to slot 1
    always_comb begin
        base   = clr ? '0 : wptr_q;
        wr_idx = base + AW'(1);
        rd_idx = wptr_q - rd_off;
    end

    assign rd_data = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            for (int i = 0; i < int'(NTAPS); i++) mem_q[i] <= '0;
        end else begin
            if (clr) begin
                wptr_q <= '0;
                for (int i = 0; i < int'(NTAPS); i++) mem_q[i] <= '0;
            end
            if (push) begin
                wptr_q         <= wr_idx;
                mem_q[wr_idx]  <= push_data;
            end
        end
    end

endmodule

// File: rtl/sfilt_seq.sv
// Command sequencer for sfilt: per sample emits cmd0, (NTAPS-1) x cmd1, cmd2, cmd3.
// Optional SFILT_SEQ_HCLR_EN adds a hist_clr input that zeroes the history in IDLE/SEND.
module sfilt_seq
    import sfilt_pkg::*;
#(
    parameter int unsigned NTAPS = 8,
    parameter int unsigned AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [31:0]   coef_wdata,
`ifdef SFILT_SEQ_HCLR_EN
    input  logic          hist_clr,
`endif
    sfilt_seq_if.slave    bus
);

    sfilt_state_e  state_q;
    logic [AW-1:0] k_q;
    logic [AW-1:0] next_k;
    logic [6:0]    shift_q;
    logic [31:0]   coef_q [NTAPS];
    logic [31:0]   hist_rd;
    logic          accept;
    logic          clr;

    assign bus.in_ready = (state_q == IDLE) || (state_q == SEND);
    assign accept       = bus.in_valid && bus.in_ready;
    // Outputs are registered, so the tap read here is the one shown next cycle
    assign next_k       = (state_q == MAC) ? k_q + AW'(1) : AW'(1);

`ifdef SFILT_SEQ_HCLR_EN
    assign clr = hist_clr && bus.in_ready;
`else
    assign clr = 1'b0;
`endif

    sfilt_seq_hist #(
        .NTAPS (NTAPS),
        .AW    (AW)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (bus.in_data),
        .clr       (clr),
        .rd_off    (next_k),
        .rd_data   (hist_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NTAPS); i++) coef_q[i] <= '0;
        end else if (coef_we) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            shift_q     <= '0;
            bus.pushout <= 1'b0;
            bus.cmd     <= CMD_MULT;
            bus.q       <= '0;
            bus.h       <= '0;
        end else if (accept) begin
            state_q     <= MULT0;
            shift_q     <= bus.shift;
            bus.pushout <= 1'b1;
            bus.cmd     <= CMD_MULT;
            bus.q       <= bus.in_data;
            bus.h       <= coef_q[0];
        end else begin
            case (state_q)
                IDLE: ;
                MULT0, MAC: begin
                    if (state_q == MAC && k_q == AW'(NTAPS - 1)) begin
                        state_q <= SHIFT;
                        bus.cmd <= CMD_SHR;
                        bus.q   <= '0;
                        bus.h   <= {25'b0, shift_q};
                    end else begin
                        state_q <= MAC;
                        k_q     <= next_k;
                        bus.cmd <= CMD_MAC;
                        bus.q   <= hist_rd;
                        bus.h   <= coef_q[next_k];
                    end
                end
                SHIFT: begin
                    state_q <= SEND;
                    bus.cmd <= CMD_SEND;
                    bus.q   <= '0;
                    bus.h   <= '0;
                end
                SEND: begin
                    state_q     <= IDLE;
                    bus.pushout <= 1'b0;
                    bus.cmd     <= CMD_MULT;
                end
                default: begin
                    state_q     <= IDLE;
                    bus.pushout <= 1'b0;
                end
            endcase
        end
    end

endmodule
